// File: rtl/filter2d_pkg.sv
// Shared types and default geometry for the double-buffered 2D filter frame controller.
package filter2d_pkg;

  localparam int unsigned W_BITS     = 8;
  localparam int unsigned H_BITS     = 8;
  localparam int unsigned NCOEF      = 9;
  localparam int unsigned COEF_W     = 8;
  localparam int unsigned COEF_BUS_W = COEF_W * NCOEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/filter2d_coef_bank.sv
// Shadow/active kernel coefficient registers; the active set only changes on commit.
module filter2d_coef_bank
  import filter2d_pkg::*;
#(
  parameter int unsigned NCOEF = filter2d_pkg::NCOEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      h_write,
  input  logic [3:0]                h_idx,
  input  logic [COEF_W-1:0]         h_data,
  input  logic                      commit,
  output logic [COEF_W*NCOEF-1:0]   coef_act
);

  logic [NCOEF-1:0][COEF_W-1:0] shadow_q;
  logic [COEF_W*NCOEF-1:0]      act_q;

  // Commit samples shadow_q before this cycle's host write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      act_q    <= '0;
    end else begin
      if (commit) begin
        act_q <= shadow_q;
      end
      for (int k = 0; k < int'(NCOEF); k++) begin
        if (h_write && (int'(h_idx) == k)) begin
          shadow_q[k] <= h_data;
        end
      end
    end
  end

  assign coef_act = act_q;

endmodule

// File: rtl/filter2d_frame_ctrl.sv
// Frame controller: ping-pong write addressing, per-frame coordinate sequencing and
// frame-synchronous kernel commit.
module filter2d_frame_ctrl
  import filter2d_pkg::*;
#(
  parameter int unsigned W_BITS = filter2d_pkg::W_BITS,
  parameter int unsigned H_BITS = filter2d_pkg::H_BITS,
  parameter int unsigned NCOEF  = filter2d_pkg::NCOEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_strb,
  input  logic [7:0]                 i_data,
  input  logic                       h_write,
  input  logic [3:0]                 h_idx,
  input  logic [7:0]                 h_data,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [W_BITS+H_BITS-1:0]   wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       p_valid,
  input  logic                       p_ready,
  output logic [H_BITS-1:0]          p_row,
  output logic [W_BITS-1:0]          p_col,
  output logic                       rd_bank,
  input  logic                       d_done,
  output logic [8*NCOEF-1:0]         coef_act,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_drop,
  output logic [15:0]                frame_cnt
);

  localparam int unsigned ABits = W_BITS + H_BITS;

  logic [ABits-1:0]  wcnt_q;
  logic              wb_q;
  logic              wr_en_q, wr_bank_q, rd_bank_q, err_drop_q;
  logic [ABits-1:0]  wr_addr_q;
  logic [7:0]        wr_data_q;

  state_e            state_q, state_d;
  logic              setup_q, setup_d;
  logic [H_BITS-1:0] row_q, row_d;
  logic [W_BITS-1:0] col_q, col_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic last_pix, proc_free, frame_start;

  assign last_pix    = i_strb && (wcnt_q == '1);
  assign proc_free   = (state_q == IDLE) || ((state_q == WAIT_DONE) && d_done);
  assign frame_start = last_pix && proc_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q     <= '0;
      wb_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_bank_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      wr_en_q <= i_strb;
      if (i_strb) begin
        wcnt_q    <= wcnt_q + ABits'(1);
        wr_bank_q <= wb_q;
        wr_addr_q <= wcnt_q;
        wr_data_q <= i_data;
      end
      // A dropped frame leaves wb_q alone so the next frame overwrites the same bank.
      if (frame_start) begin
        wb_q      <= ~wb_q;
        rd_bank_q <= wb_q;
      end
      if (last_pix && !proc_free) begin
        err_drop_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    setup_d      = 1'b0;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (!setup_q && p_ready) begin
          if (col_q == '1) begin
            col_d = '0;
            if (row_q == '1) begin
              row_d   = '0;
              state_d = WAIT_DONE;
            end else begin
              row_d = row_q + H_BITS'(1);
            end
          end else begin
            col_d = col_q + W_BITS'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (d_done) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The setup cycle lets the final pixel write land before the bank is read.
    if (frame_start) begin
      state_d = RUN;
      setup_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      setup_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      setup_q      <= setup_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  filter2d_coef_bank #(
    .NCOEF (NCOEF)
  ) u_coef_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .h_write  (h_write),
    .h_idx    (h_idx),
    .h_data   (h_data),
    .commit   (frame_start),
    .coef_act (coef_act)
  );

  assign wr_en      = wr_en_q;
  assign wr_bank    = wr_bank_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign p_valid    = (state_q == RUN) && !setup_q;
  assign p_row      = row_q;
  assign p_col      = col_q;
  assign rd_bank    = rd_bank_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign err_drop   = err_drop_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_filter2d_frame_ctrl.sv
// Scoreboard bench for filter2d_frame_ctrl on a 4x4 image with a frame-level reference model.
module tb_filter2d_frame_ctrl;

  localparam int unsigned WB   = 2;
  localparam int unsigned HB   = 2;
  localparam int unsigned NC   = 9;
  localparam int          NPIX = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             i_strb = 1'b0;
  logic [7:0]       i_data = '0;
  logic             h_write = 1'b0;
  logic [3:0]       h_idx = '0;
  logic [7:0]       h_data = '0;
  logic             p_ready = 1'b1;
  logic             d_done = 1'b0;
  logic             wr_en, wr_bank, p_valid, rd_bank, busy, frame_done, err_drop;
  logic [WB+HB-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [HB-1:0]    p_row;
  logic [WB-1:0]    p_col;
  logic [8*NC-1:0]  coef_act;
  logic [15:0]      frame_cnt;

  always #5 clk = ~clk;

  filter2d_frame_ctrl #(
    .W_BITS (WB),
    .H_BITS (HB),
    .NCOEF  (NC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_strb     (i_strb),
    .i_data     (i_data),
    .h_write    (h_write),
    .h_idx      (h_idx),
    .h_data     (h_data),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .p_row      (p_row),
    .p_col      (p_col),
    .rd_bank    (rd_bank),
    .d_done     (d_done),
    .coef_act   (coef_act),
    .busy       (busy),
    .frame_done (frame_done),
    .err_drop   (err_drop),
    .frame_cnt  (frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int wq[$];
  int cq[$];
  int hs_cnt = 0;
  int hs_target = 0;

  // Reference model state: pixel index within frame, fill bank, frame in flight.
  int         m_pix = 0;
  int         m_wb = 0;
  int         m_frames = 0;
  bit         m_active = 1'b0;
  bit         m_err = 1'b0;
  bit         rdy_rand = 1'b0;
  logic [7:0] m_shadow [NC];
  logic [7:0] m_act [NC];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_coef(input string name);
    logic [8*NC-1:0] exp;
    for (int k = 0; k < int'(NC); k++) exp[8*k +: 8] = m_act[k];
    checks++;
    if (coef_act !== exp) begin
      errors++;
      $display("FAIL %s: coef_act got 0x%0h, expected 0x%0h", name, coef_act, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    cq.delete();
    hs_target = hs_cnt;
    m_pix = 0;
    m_wb = 0;
    m_frames = 0;
    m_active = 1'b0;
    m_err = 1'b0;
    for (int k = 0; k < int'(NC); k++) begin
      m_shadow[k] = '0;
      m_act[k] = '0;
    end
  endtask

  task automatic chk_reset();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_p_valid", p_valid, 0);
    chk("rst_p_row", p_row, 0);
    chk("rst_p_col", p_col, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_drop", err_drop, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk_coef("rst_coef");
  endtask

  // Drives one clock cycle of inputs and advances the model with the same event.
  task automatic cycle(input bit strb, input logic [7:0] data, input bit done,
                       input bit hw, input logic [3:0] hidx, input logic [7:0] hdat);
    i_strb  = strb;
    i_data  = data;
    d_done  = done;
    h_write = hw;
    h_idx   = hidx;
    h_data  = hdat;
    p_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (done && m_active && (hs_cnt == hs_target)) begin
      m_active = 1'b0;
      m_frames++;
    end
    if (strb) begin
      wq.push_back((m_wb << 12) | (m_pix << 8) | int'(data));
      if (m_pix == NPIX - 1) begin
        if (!m_active) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cq.push_back((m_wb << 8) | (r << 4) | c);
          hs_target += NPIX;
          m_wb ^= 1;
          m_active = 1'b1;
          m_act = m_shadow;
        end else begin
          m_err = 1'b1;
        end
      end
      m_pix = (m_pix + 1) % NPIX;
    end
    if (hw && (int'(hidx) < int'(NC))) m_shadow[hidx] = hdat;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic send_frame(input bit done_last, input bit gaps, input bit seq);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
      cycle(1'b1, seq ? 8'(i) : 8'($urandom), done_last && (i == NPIX - 1), 1'b0, 4'h0, 8'h00);
    end
  endtask

  task automatic wait_hs();
    int n = 0;
    while ((hs_cnt != hs_target) && (n < 500)) begin
      idle(1);
      n++;
    end
    chk("handshake_count", hs_cnt, hs_target);
  endtask

  task automatic finish_frame();
    wait_hs();
    idle(2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
    chk("frame_done_pulse", frame_done, 1);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("busy_after_done", busy, m_active);
    idle(1);
    chk("frame_done_single", frame_done, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: addr 0x%0h bank %0d, expected no write", wr_addr, wr_bank);
        end else begin
          chk("wr_bank_addr_data",
              (int'(wr_bank) << 12) | (int'(wr_addr) << 8) | int'(wr_data), wq.pop_front());
        end
      end
      if (p_valid && p_ready) begin
        hs_cnt++;
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL coord_unexpected: row %0d col %0d, expected no handshake", p_row, p_col);
        end else begin
          chk("coord_rdbank_row_col",
              (int'(rd_bank) << 8) | (int'(p_row) << 4) | int'(p_col), cq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    chk_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Frame 0: sequential data, check frame-start latency.
    for (int i = 0; i < NPIX; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 4'h0, 8'h00);
    chk("start_busy", busy, 1);
    chk("start_setup_no_valid", p_valid, 0);
    chk("start_rd_bank", rd_bank, 0);
    idle(1);
    chk("first_valid", p_valid, 1);
    chk("first_row", p_row, 0);
    chk("first_col", p_col, 0);
    finish_frame();

    // Random data with gaps and random p_ready stalls.
    rdy_rand = 1'b1;
    send_frame(1'b0, 1'b1, 1'b0);
    finish_frame();
    send_frame(1'b0, 1'b1, 1'b0);
    finish_frame();
    rdy_rand = 1'b0;

    // Drop: next frame arrives while the previous waits for d_done.
    send_frame(1'b0, 1'b0, 1'b0);
    wait_hs();
    idle(2);
    send_frame(1'b0, 1'b0, 1'b0);
    chk("err_drop_set", err_drop, m_err);
    chk("busy_held_on_drop", busy, 1);
    finish_frame();
    send_frame(1'b0, 1'b1, 1'b0);
    finish_frame();
    chk("err_drop_sticky", err_drop, 1);

    // d_done coincides with the last pixel of the next frame.
    send_frame(1'b0, 1'b0, 1'b0);
    wait_hs();
    idle(2);
    send_frame(1'b1, 1'b0, 1'b0);
    chk("restart_busy", busy, 1);
    chk("restart_frame_done", frame_done, 1);
    chk("restart_frame_cnt", frame_cnt, m_frames);
    chk("restart_rd_bank", rd_bank, m_wb ^ 1);
    finish_frame();

    // Coefficients: mid-frame shadow write, ignored index, write colliding with commit.
    for (int i = 0; i < NPIX; i++) begin
      if (i == 5) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 4'd4, 8'h7F);
      else if (i == 8) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 4'd12, 8'h55);
      else if (i == NPIX - 1) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 4'd2, 8'hA5);
      else cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 4'h0, 8'h00);
      if (i == 9) chk_coef("coef_unchanged_midframe");
    end
    chk_coef("coef_commit_old_shadow");
    chk("coef4_active", coef_act[39:32], 8'h7F);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'(k * 2), 8'($urandom));
    finish_frame();
    send_frame(1'b0, 1'b1, 1'b0);
    chk_coef("coef_second_commit");
    finish_frame();

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 4'h0, 8'h00);
    reset_n = 1'b0;
    model_reset();
    #2;
    chk_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    send_frame(1'b0, 1'b0, 1'b0);
    chk("post_reset_rd_bank", rd_bank, 0);
    finish_frame();

    idle(3);
    chk("write_queue_drained", wq.size(), 0);
    chk("coord_queue_drained", cq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
